// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO controller: register map, CNF bit positions
// and the bus handshake state encoding.
package gpio_pkg;

    localparam logic [1:0] ADDR_CNF  = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_DOUT = 2'd2;
    localparam logic [1:0] ADDR_DIN  = 2'd3;

    localparam int CNF_IE   = 0;
    localparam int CNF_NEW  = 1;
    localparam int CNF_RISE = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/gpio_edge_detect.sv
// Two-flop pad synchronizer plus a "previous" flop; produces the synchronized
// pin vector and a per-pin change vector (any edge or rising only).
module gpio_edge_detect #(
    parameter int PINS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rise,
    input  logic [PINS-1:0] pin_in,
    output logic [PINS-1:0] sync,
    output logic [PINS-1:0] edges
);

    logic [PINS-1:0] sync1_q, sync1_d;
    logic [PINS-1:0] sync2_q, sync2_d;
    logic [PINS-1:0] prev_q,  prev_d;

    always_comb begin
        sync1_d = pin_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // prev is not masked after reset, so a pin already high reads as a rising edge.
    assign sync  = sync2_q;
    assign edges = rise ? (sync2_q & ~prev_q) : (sync2_q ^ prev_q);

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller: four-register bus slave (CNF/DIR/DOUT/DIN) behind a
// four-phase req/ack handshake, with sticky change detection and level irq.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int SIZE = 32,
    parameter int PINS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [SIZE-1:0] wdata,
    output logic [SIZE-1:0] rdata,
    output logic            ack,
    input  logic [PINS-1:0] pin_in,
    output logic [PINS-1:0] pin_out,
    output logic [PINS-1:0] pin_oe,
    output logic            irq
);

    state_e          state_q, state_d;
    logic            ie_q, ie_d;
    logic            new_q, new_d;
    logic            rise_q, rise_d;
    logic            irq_q, irq_d;
    logic [PINS-1:0] dir_q, dir_d;
    logic [PINS-1:0] dout_q, dout_d;
    logic [SIZE-1:0] rdata_q, rdata_d;

    logic [PINS-1:0] pin_sync;
    logic [PINS-1:0] pin_edges;
    logic            wr_en, rd_en, new_clr;
    logic            wdata_unused;

    gpio_edge_detect #(.PINS(PINS)) u_edge (
        .clk    (clk),
        .rst    (rst),
        .rise   (rise_q),
        .pin_in (pin_in),
        .sync   (pin_sync),
        .edges  (pin_edges)
    );

    assign wr_en   = (state_q == ST_ACCESS) && we;
    assign rd_en   = (state_q == ST_ACCESS) && !we;
    assign new_clr = wr_en && (addr == ADDR_CNF) && wdata[CNF_NEW];

    always_comb begin
        state_d = state_q;
        ie_d    = ie_q;
        rise_d  = rise_q;
        dir_d   = dir_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;

        unique case (state_q)
            ST_IDLE:   if (req) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   if (!req) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (wr_en) begin
            unique case (addr)
                ADDR_CNF: begin
                    ie_d   = wdata[CNF_IE];
                    rise_d = wdata[CNF_RISE];
                end
                ADDR_DIR:  dir_d  = wdata[PINS-1:0];
                ADDR_DOUT: dout_d = wdata[PINS-1:0];
                default: ;
            endcase
        end

        // CNF reads see NEW as it stands during the ACCESS cycle.
        if (rd_en) begin
            rdata_d = '0;
            unique case (addr)
                ADDR_CNF: begin
                    rdata_d[CNF_IE]   = ie_q;
                    rdata_d[CNF_NEW]  = new_q;
                    rdata_d[CNF_RISE] = rise_q;
                end
                ADDR_DIR:  rdata_d[PINS-1:0] = dir_q;
                ADDR_DOUT: rdata_d[PINS-1:0] = dout_q;
                default:   rdata_d[PINS-1:0] = pin_sync;
            endcase
        end

        // A fresh edge beats a same-cycle write-1-to-clear.
        new_d = (|pin_edges) | (new_q & ~new_clr);
        irq_d = ie_q & new_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ie_q    <= 1'b0;
            new_q   <= 1'b0;
            rise_q  <= 1'b0;
            irq_q   <= 1'b0;
            dir_q   <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            new_q   <= new_d;
            rise_q  <= rise_d;
            irq_q   <= irq_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
        end
    end

    assign wdata_unused = ^wdata;

    assign rdata   = rdata_q;
    assign ack     = (state_q == ST_RESP);
    assign pin_out = dout_q;
    assign pin_oe  = dir_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Bench for gpio_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic [7:0]  pin_in = '0;
    logic [7:0]  pin_out;
    logic [7:0]  pin_oe;
    logic        irq;

    int n_cmp = 0;
    int n_mis = 0;

    gpio_ctrl #(.SIZE(32), .PINS(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ack     (ack),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Handshake phase: 0 waiting for req, 1 register access cycle, 2 responding.
    int         m_phase = 0;
    logic       m_ie = 0, m_new = 0, m_rise = 0, m_irq = 0;
    logic [7:0] m_dir = 0, m_dout = 0;
    logic [31:0] m_rdata = 0;
    logic [7:0] pin_hist[$] = '{8'h00, 8'h00, 8'h00}; // samples, newest first
    bit         mdl_live = 0;

    always @(posedge clk) begin
        logic [7:0] sync_v, prev_v, ev;
        logic       o_ie, o_new, clr;
        if (rst) begin
            m_phase = 0; m_ie = 0; m_new = 0; m_rise = 0; m_irq = 0;
            m_dir = 0; m_dout = 0; m_rdata = 0;
            mdl_live = 1;
        end else begin
            sync_v = pin_hist[1];
            prev_v = pin_hist[2];
            ev = m_rise ? (sync_v & ~prev_v) : (sync_v ^ prev_v);
            o_ie = m_ie; o_new = m_new; clr = 0;
            if (m_phase == 1) begin
                if (we) begin
                    case (addr)
                        2'd0: begin m_ie = wdata[0]; m_rise = wdata[2]; clr = wdata[1]; end
                        2'd1: m_dir = wdata[7:0];
                        2'd2: m_dout = wdata[7:0];
                        default: ;
                    endcase
                end else begin
                    case (addr)
                        2'd0: m_rdata = {29'd0, m_rise, o_new, o_ie};
                        2'd1: m_rdata = {24'd0, m_dir};
                        2'd2: m_rdata = {24'd0, m_dout};
                        default: m_rdata = {24'd0, sync_v};
                    endcase
                end
            end
            m_new = (ev != 0) || (o_new && !clr);
            m_irq = o_ie & o_new;
            if (m_phase == 0) m_phase = req ? 1 : 0;
            else if (m_phase == 1) m_phase = 2;
            else m_phase = req ? 2 : 0;
        end
        pin_hist.push_front(rst ? 8'h00 : pin_in);
        void'(pin_hist.pop_back());
    end

    always @(negedge clk) begin
        if (mdl_live) begin
            chk("ack", {31'd0, ack}, {31'd0, m_phase == 2});
            chk("pin_out", {24'd0, pin_out}, {24'd0, m_dout});
            chk("pin_oe", {24'd0, pin_oe}, {24'd0, m_dir});
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
            if (m_phase == 2) chk("rdata", rdata, m_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input int hold, output logic [31:0] rd, output int lat);
        req = 1'b1; we = w; addr = a; wdata = d; lat = 0;
        while (!ack && lat < 8) begin
            step();
            lat++;
        end
        chk("ack_seen", {31'd0, ack}, 32'd1);
        rd = rdata;
        repeat (hold) step();
        req = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] rd;
        int lat;

        repeat (3) step();
        rst = 1'b0;
        chk("rst_pin_out", {24'd0, pin_out}, 32'h0);
        chk("rst_pin_oe", {24'd0, pin_oe}, 32'h0);
        chk("rst_ack", {31'd0, ack}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        step();

        // DIR/DOUT writes, two-clock ack latency
        bus(1, 2'd1, 32'h0F, 0, rd, lat);
        chk("dir_lat", lat, 2);
        bus(1, 2'd2, 32'hA5, 0, rd, lat);
        chk("dout_lat", lat, 2);
        chk("pin_oe_0f", {24'd0, pin_oe}, 32'h0F);
        chk("pin_out_a5", {24'd0, pin_out}, 32'hA5);

        // IE, any-edge detection latency, W1C
        bus(1, 2'd0, 32'h1, 0, rd, lat);
        pin_in = 8'h01;
        repeat (3) step();
        chk("irq_before", {31'd0, irq}, 32'h0);
        step();
        chk("irq_after", {31'd0, irq}, 32'h1);
        bus(1, 2'd0, 32'h3, 0, rd, lat);
        step();
        chk("irq_cleared", {31'd0, irq}, 32'h0);
        bus(0, 2'd0, 32'h0, 0, rd, lat);
        chk("cnf_after_w1c", rd, 32'h1);

        // Rising-only mode
        bus(1, 2'd0, 32'h7, 0, rd, lat);
        pin_in = 8'h00;
        repeat (5) step();
        bus(0, 2'd0, 32'h0, 0, rd, lat);
        chk("fall_ignored", rd, 32'h5);
        pin_in = 8'h80;
        repeat (5) step();
        bus(0, 2'd0, 32'h0, 0, rd, lat);
        chk("rise_seen", rd, 32'h7);

        // W1C committed on the same edge NEW is set by a fresh edge
        bus(1, 2'd0, 32'h7, 0, rd, lat);
        repeat (4) step();
        bus(0, 2'd0, 32'h0, 0, rd, lat);
        chk("new_clear_pre", rd, 32'h5);
        pin_in = 8'h81;
        step();
        bus(1, 2'd0, 32'h7, 0, rd, lat);
        bus(0, 2'd0, 32'h0, 0, rd, lat);
        chk("set_beats_clr", rd, 32'h7);

        // Long req hold, then DIN read
        bus(1, 2'd2, 32'h3C, 10, rd, lat);
        chk("hold_dout", {24'd0, pin_out}, 32'h3C);
        chk("hold_idle_ack", {31'd0, ack}, 32'h0);
        pin_in = 8'h5A;
        repeat (4) step();
        bus(0, 2'd3, 32'h0, 0, rd, lat);
        chk("din_read", rd, 32'h0000005A);
        bus(1, 2'd3, 32'hFF, 0, rd, lat);
        bus(0, 2'd3, 32'h0, 0, rd, lat);
        chk("din_wr_ignored", rd, 32'h0000005A);

        // Reset in the ACCESS cycle aborts the write
        req = 1'b1; we = 1'b1; addr = 2'd2; wdata = 32'hFF;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; req = 1'b0;
        chk("abort_ack", {31'd0, ack}, 32'h0);
        repeat (3) begin
            step();
            chk("abort_ack_hold", {31'd0, ack}, 32'h0);
        end
        chk("abort_dout", {24'd0, pin_out}, 32'h0);
        chk("abort_dir", {24'd0, pin_oe}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) pin_in = 8'($urandom);
            bus(1'($urandom), 2'($urandom), $urandom, $urandom_range(0, 3), rd, lat);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 Parameter SIZE, default 32, bus data width.
REQ-002 Parameter PINS, default 8, GPIO pin count (PINS <= SIZE).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  bus access request, four-phase handshake.
REQ-006 we  input  1  1 = write, 0 = read; valid while req high.
REQ-007 addr  input  2  register select: 0 CNF, 1 DIR, 2 DOUT, 3 DIN.
REQ-008 wdata  input  SIZE  write data; valid while req high.
REQ-009 rdata  output  SIZE  read data; valid while ack high.
REQ-010 ack  output  1  access complete.
REQ-011 pin_in  input  PINS  asynchronous pad inputs.
REQ-012 pin_out  output  PINS  pad output values, equal to DOUT.
REQ-013 pin_oe  output  PINS  pad output enables, equal to DIR (1 = drive).
REQ-014 irq  output  1  registered interrupt, level.

Function
REQ-015 CNF SHALL have bit0 IE (interrupt enable, R/W), bit1 NEW (sticky change flag, write-1-to-clear), bit2 RISE (0 = any edge, 1 = rising edge only, R/W); other bits read 0.
REQ-016 DIR and DOUT SHALL be PINS-bit R/W registers, zero-extended on read.
REQ-017 DIN SHALL read the synchronized pin value; writes to DIN are ignored but still acknowledged.
REQ-018 pin_in SHALL pass through two synchronizer flops, then a third "previous" flop; edge vector = sync ^ prev (RISE=0) or sync & ~prev (RISE=1).
REQ-019 Any edge-vector bit set SHALL set NEW on the next clock; detection latency from pin_in change to NEW = 3 clocks.
REQ-020 Set SHALL win over clear: a W1C of NEW in the same cycle as a detected edge leaves NEW = 1.
REQ-021 irq SHALL be registered as IE & NEW, i.e. one clock after NEW/IE change.
REQ-022 The handshake FSM SHALL have states IDLE, ACCESS, RESP.
REQ-023 IDLE -> ACCESS when req = 1; otherwise remain.
REQ-024 In ACCESS the write is committed (we = 1) or rdata is captured (we = 0); unconditional transition to RESP.
REQ-025 In RESP, ack = 1; remain while req = 1; -> IDLE when req = 0.
REQ-026 ack SHALL be 0 in IDLE and ACCESS; exactly one register update per handshake, regardless of how long req stays high.
REQ-027 rdata SHALL hold its captured value until the next read capture; writes do not alter rdata.
REQ-028 A read of CNF SHALL return NEW as sampled in the ACCESS cycle.

Reset
REQ-029 While rst = 1 at a clock edge: CNF, DIR, DOUT, rdata, and all synchronizer/prev flops SHALL be 0; FSM -> IDLE; ack = 0; irq = 0.
REQ-030 Reset during ACCESS or RESP SHALL abort the access, leaving no register update committed in that cycle.
REQ-031 After reset release, the first two cycles of prev = 0 SHALL NOT be masked; a pin already high when RISE = 1 may set NEW (documented behaviour).

Structure
REQ-032 Shared package gpio_pkg SHALL hold the address constants (CNF/DIR/DOUT/DIN), the CNF bit indices (IE, NEW, RISE), and the FSM state encoding.
REQ-033 One sub-module, gpio_edge_detect (synchronizer + prev flop + edge vector, parameter PINS, input RISE), SHALL be instantiated; the register file and FSM stay in gpio_ctrl.

Verification
REQ-034 Write DIR = 0x0F, then DOUT = 0xA5 -> ack asserted 2 clocks after req in each access; pin_oe = 0x0F, pin_out = 0xA5.
REQ-035 CNF = 0x1 (IE), pin_in 0x00 -> 0x01 -> NEW = 1 exactly 3 clocks later, irq = 1 one clock after; write CNF = 0x3 -> NEW = 0, IE stays 1, irq = 0.
REQ-036 RISE = 1, pin_in 0x01 -> 0x00 -> NEW stays 0; then 0x00 -> 0x80 -> NEW = 1.
REQ-037 W1C of NEW issued in the same cycle as a detected edge -> NEW remains 1.
REQ-038 req held high for 10 clocks on a DOUT write of 0x3C -> single update, ack high until req drops, FSM back in IDLE 1 clock later; read DIN with pin_in = 0x5A stable -> rdata = 0x0000005A.
REQ-039 rst asserted in the ACCESS cycle of a DOUT write of 0xFF -> DOUT = 0, ack never asserted, FSM in IDLE.
